power_spec_accum: RTL

Parametrised successor to the single-frame power-spectrum stage. It consumes the complex FFT output stream (xk_re/xk_im/xk_index/dv) and computes |X[k]|² = re² + im² per bin. It sums that result over a programmable number of consecutive FFT frames in an internal per-bin accumulator RAM. On the last frame it streams the accumulated spectrum with bin index and valid to the peak-search / DPRAM logic downstream.

---
 rtl/psc_pkg.sv | 18 +
 rtl/spec_acc_ram.sv | 27 ++
 rtl/power_spec_accum.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/psc_pkg.sv
// Shared definitions for the multi-frame power-spectrum accumulator.
package psc_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int NFFT_LOG2_DEF = 10;
  localparam int ACC_W_DEF     = 48;
  localparam int CNT_W_DEF     = 16;

  // Cycles from an accepted FFT sample to its spec_* output.
  localparam int PIPE_LAT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } psc_state_e;

endpackage

// File: rtl/spec_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM, one write port and one
// synchronous read port with single-cycle read latency.
module spec_acc_ram
  import psc_pkg::*;
#(
  parameter int AW = NFFT_LOG2_DEF,
  parameter int DW = ACC_W_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];

  // Synchronous write and registered read, no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/power_spec_accum.sv
// Computes |X[k]|^2 of the FFT output stream and sums it per bin over a
// programmable number of frames; the final frame streams the totals out.
module power_spec_accum
  import psc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accum_start,
  input  logic [CNT_W-1:0]     accum_num,
  input  logic                 dv,
  input  logic [NFFT_LOG2-1:0] xk_index,
  input  logic [DATA_W-1:0]    xk_re,
  input  logic [DATA_W-1:0]    xk_im,
  output logic [ACC_W-1:0]     spec_data,
  output logic [NFFT_LOG2-1:0] spec_index,
  output logic                 spec_valid,
  output logic                 accum_done,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [NFFT_LOG2-1:0] LAST_BIN = {NFFT_LOG2{1'b1}};
  localparam logic [ACC_W-1:0]     ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0]     ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  psc_state_e state_r, state_s;
  logic [CNT_W-1:0] num_r, frame_cnt_r;
  logic accept_s, start_ok_s;

  // S1..S4 pipeline registers
  logic                     v1_r, first1_r, final1_r, lastb1_r;
  logic [NFFT_LOG2-1:0]     idx1_r;
  logic signed [DATA_W-1:0] re1_r, im1_r;
  logic                     v2_r, first2_r, final2_r, lastb2_r;
  logic [NFFT_LOG2-1:0]     idx2_r;
  logic signed [PROD_W-1:0] pre2_r, pim2_r;
  logic                     v3_r, first3_r, final3_r, lastb3_r;
  logic [NFFT_LOG2-1:0]     idx3_r;
  logic [PROD_W-1:0]        pwr3_r;
  logic [ACC_W-1:0]         rd3_r;
  logic                     v4_r, final4_r, lastb4_r, sat4_r;
  logic [NFFT_LOG2-1:0]     idx4_r;
  logic [ACC_W-1:0]         acc4_r;

  logic [ACC_W-1:0] ram_rdata_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_s;
  logic             sat_s;

  // Next-state logic and sample acceptance; after the final frame is fed,
  // further dv is ignored until the last result leaves the pipeline.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    start_ok_s = accum_start && (state_r == IDLE);
    case (state_r)
      IDLE: begin
        if (accum_start) state_s = ARMED;
        else             state_s = IDLE;
      end
      ARMED: begin
        accept_s = dv && (xk_index == '0);
        if (accept_s) state_s = RUN;
        else          state_s = ARMED;
      end
      RUN: begin
        accept_s = dv && (frame_cnt_r != num_r);
        if (accum_done) state_s = IDLE;
        else            state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state and busy flag; busy drops together with the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
    end
  end

  // Frame count target (0 means 1) and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r       <= '0;
      frame_cnt_r <= '0;
    end else if (start_ok_s) begin
      num_r       <= (accum_num == '0) ? ONE_CNT : accum_num;
      frame_cnt_r <= '0;
    end else if (accept_s && (xk_index == LAST_BIN)) begin
      frame_cnt_r <= frame_cnt_r + ONE_CNT;
    end
  end

  // S1: capture the accepted sample and tag it with its frame role.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0; first1_r <= 1'b0; final1_r <= 1'b0; lastb1_r <= 1'b0;
      idx1_r <= '0; re1_r <= '0; im1_r <= '0;
    end else begin
      v1_r     <= accept_s;
      first1_r <= (frame_cnt_r == '0);
      final1_r <= (frame_cnt_r == (num_r - ONE_CNT));
      lastb1_r <= (xk_index == LAST_BIN);
      idx1_r   <= xk_index;
      re1_r    <= xk_re;
      im1_r    <= xk_im;
    end
  end

  // S2: signed squares, mapped onto DSP multipliers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r <= 1'b0; first2_r <= 1'b0; final2_r <= 1'b0; lastb2_r <= 1'b0;
      idx2_r <= '0; pre2_r <= '0; pim2_r <= '0;
    end else begin
      v2_r <= v1_r; first2_r <= first1_r; final2_r <= final1_r; lastb2_r <= lastb1_r;
      idx2_r <= idx1_r;
      pre2_r <= re1_r * re1_r;
      pim2_r <= im1_r * im1_r;
    end
  end

  // S3: power sum (both squares are non-negative, so it fits PROD_W bits)
  // and capture of the previous accumulation for this bin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r <= 1'b0; first3_r <= 1'b0; final3_r <= 1'b0; lastb3_r <= 1'b0;
      idx3_r <= '0; pwr3_r <= '0; rd3_r <= '0;
    end else begin
      v3_r <= v2_r; first3_r <= first2_r; final3_r <= final2_r; lastb3_r <= lastb2_r;
      idx3_r <= idx2_r;
      pwr3_r <= $unsigned(pre2_r) + $unsigned(pim2_r);
      rd3_r  <= ram_rdata_s;
    end
  end

  // Saturating accumulate; frame 0 ignores stale RAM contents.
  always_comb begin
    sum_s = {1'b0, rd3_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, pwr3_r};
    acc_s = '0;
    sat_s = 1'b0;
    if (first3_r) begin
      acc_s = {{(ACC_W - PROD_W){1'b0}}, pwr3_r};
    end else if (sum_s[ACC_W]) begin
      acc_s = ACC_MAX;
      sat_s = 1'b1;
    end else begin
      acc_s = sum_s[ACC_W-1:0];
    end
  end

  // S4: register the accumulated value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4_r <= 1'b0; final4_r <= 1'b0; lastb4_r <= 1'b0; sat4_r <= 1'b0;
      idx4_r <= '0; acc4_r <= '0;
    end else begin
      v4_r <= v3_r; final4_r <= final3_r; lastb4_r <= lastb3_r;
      sat4_r <= v3_r && sat_s;
      idx4_r <= idx3_r;
      acc4_r <= acc_s;
    end
  end

  // S5: output registers for the final frame, plus the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_valid <= 1'b0;
      accum_done <= 1'b0;
      spec_data  <= '0;
      spec_index <= '0;
      overflow   <= 1'b0;
    end else begin
      spec_valid <= v4_r && final4_r;
      accum_done <= v4_r && final4_r && lastb4_r;
      if (v4_r && final4_r) begin
        spec_data  <= acc4_r;
        spec_index <= idx4_r;
      end
      if (start_ok_s)  overflow <= 1'b0;
      else if (sat4_r) overflow <= 1'b1;
    end
  end

  // Read in S1, write back in S5; same-bin accesses are a frame apart.
  spec_acc_ram #(.AW(NFFT_LOG2), .DW(ACC_W)) u_ram (
    .clk   (clk),
    .we    (v4_r),
    .waddr (idx4_r),
    .wdata (acc4_r),
    .raddr (idx1_r),
    .rdata (ram_rdata_s)
  );

endmodule
